// File: rtl/detector_pulsacion.sv
// ---------------------------------------------------------------------------
// detector_pulsacion
//   Classifies presses of a debounced button sampled at a slow tick clock.
//   A press shorter than LONG_TICKS samples raises press_short on release.
//   A hold of LONG_TICKS samples raises press_long. While the hold continues
//   and repeat_en is high, repeat_pulse fires every REPEAT_TICKS samples.
//   After reset the button must be seen released before any press counts,
//   so a press already in progress at reset never produces an event.
//
// Parameters
//   LONG_TICKS   : held samples for a long press (2..65535)
//   REPEAT_TICKS : held samples between auto-repeat pulses (1..65535)
//
// Ports
//   clk_slow     in   tick clock, all registers update on its rising edge
//   rst          in   synchronous active-high reset
//   btn_stable   in   debounced button level, 1 = pressed
//   repeat_en    in   enables auto-repeat while in long hold
//   press_short  out  1-cycle pulse on release of a short press
//   press_long   out  1-cycle pulse when the hold reaches LONG_TICKS
//   repeat_pulse out  1-cycle pulse every REPEAT_TICKS of continued hold
//   held         out  level, 1 while a press is being tracked
//   press_count  out  short-press count, wraps modulo 256
//   All outputs are registered.
// ---------------------------------------------------------------------------
module detector_pulsacion #(
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 200
) (
  input  logic       clk_slow,
  input  logic       rst,
  input  logic       btn_stable,
  input  logic       repeat_en,
  output logic       press_short,
  output logic       press_long,
  output logic       repeat_pulse,
  output logic       held,
  output logic [7:0] press_count
);

  typedef enum logic [1:0] {
    WAIT_RELEASE,
    IDLE,
    PRESSED,
    LONG_HELD
  } state_t;

  // Terminal counts: the counter value seen on the edge that completes
  // the interval, so the pulse lands exactly on the last sample.
  localparam logic [15:0] LONG_LAST   = 16'(LONG_TICKS - 1);
  localparam logic [15:0] REPEAT_LAST = 16'(REPEAT_TICKS - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        short_d, long_d, repeat_d;
  logic [7:0]  count_d;

  // Next-state and next-output logic.
  // NOTE: every signal assigned here gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    short_d  = 1'b0;
    long_d   = 1'b0;
    repeat_d = 1'b0;
    count_d  = press_count;

    case (state_q)
      WAIT_RELEASE: begin
        cnt_d = '0;
        if (!btn_stable) state_d = IDLE;
      end

      IDLE: begin
        cnt_d = '0;
        if (btn_stable) begin
          // The first pressed sample already counts as one.
          state_d = PRESSED;
          cnt_d   = 16'd1;
        end
      end

      PRESSED: begin
        if (!btn_stable) begin
          state_d = IDLE;
          cnt_d   = '0;
          short_d = 1'b1;
          count_d = press_count + 8'd1;
        end else if (cnt_q == LONG_LAST) begin
          state_d = LONG_HELD;
          cnt_d   = '0;
          long_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      LONG_HELD: begin
        if (!btn_stable) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (!repeat_en) begin
          // Holding at zero makes a re-enable wait a full interval.
          cnt_d = '0;
        end else if (cnt_q == REPEAT_LAST) begin
          cnt_d    = '0;
          repeat_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      default: begin
        state_d = WAIT_RELEASE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_slow) begin
    if (rst) begin
      state_q      <= WAIT_RELEASE;
      cnt_q        <= '0;
      press_short  <= 1'b0;
      press_long   <= 1'b0;
      repeat_pulse <= 1'b0;
      held         <= 1'b0;
      press_count  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      press_short  <= short_d;
      press_long   <= long_d;
      repeat_pulse <= repeat_d;
      // Registered from the next state so held tracks the state being entered.
      held         <= (state_d == PRESSED) || (state_d == LONG_HELD);
      press_count  <= count_d;
    end
  end

endmodule

// File: tb/tb_detector_pulsacion.sv
// ---------------------------------------------------------------------------
// tb_detector_pulsacion
//   Directed vector table for the main press scenarios (LONG_TICKS=8,
//   REPEAT_TICKS=3), a wrap sequence for press_count, a second instance
//   with LONG_TICKS=2 / REPEAT_TICKS=1, and a random stream against a
//   run-length reference model.
// ---------------------------------------------------------------------------
module tb_detector_pulsacion;

  localparam int LT = 8;
  localparam int RT = 3;

  logic       clk_slow = 1'b0;
  logic       rst = 1'b1;
  logic       btn_stable = 1'b0;
  logic       repeat_en = 1'b0;
  logic       press_short, press_long, repeat_pulse, held;
  logic [7:0] press_count;

  logic       s2, l2, r2, h2;
  logic [7:0] c2;

  int total = 0;
  int bad   = 0;

  always #5 clk_slow = ~clk_slow;

  detector_pulsacion #(.LONG_TICKS(LT), .REPEAT_TICKS(RT)) dut (
    .clk_slow    (clk_slow),
    .rst         (rst),
    .btn_stable  (btn_stable),
    .repeat_en   (repeat_en),
    .press_short (press_short),
    .press_long  (press_long),
    .repeat_pulse(repeat_pulse),
    .held        (held),
    .press_count (press_count)
  );

  detector_pulsacion #(.LONG_TICKS(2), .REPEAT_TICKS(1)) dut_fast (
    .clk_slow    (clk_slow),
    .rst         (rst),
    .btn_stable  (btn_stable),
    .repeat_en   (repeat_en),
    .press_short (s2),
    .press_long  (l2),
    .repeat_pulse(r2),
    .held        (h2),
    .press_count (c2)
  );

  typedef struct {
    logic       rst;
    logic       btn;
    logic       ren;
    logic       s;
    logic       l;
    logic       r;
    logic       h;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic r_, b, e, s, l, r, h, input logic [7:0] c);
    vec_t v;
    v.rst = r_; v.btn = b; v.ren = e;
    v.s = s; v.l = l; v.r = r; v.h = h; v.cnt = c;
    vecs.push_back(v);
  endtask

  task automatic add_n(input int n, input logic b, e, h, input logic [7:0] c);
    for (int i = 0; i < n; i++) add(1'b0, b, e, 1'b0, 1'b0, 1'b0, h, c);
  endtask

  // Drive inputs for one sample and wait until just after the edge.
  task automatic step(input logic r_, b, e);
    rst = r_; btn_stable = b; repeat_en = e;
    @(posedge clk_slow);
    #1;
  endtask

  task automatic step_fast(input string tag, input logic r_, b, e, s, l, r, h, input logic [7:0] c);
    step(r_, b, e);
    check({tag, " short"}, 32'(s2), 32'(s));
    check({tag, " long"},  32'(l2), 32'(l));
    check({tag, " rep"},   32'(r2), 32'(r));
    check({tag, " held"},  32'(h2), 32'(h));
    check({tag, " count"}, 32'(c2), 32'(c));
  endtask

  initial begin
    // Reference model state for the random stream.
    bit         armed;
    int         run, rrun;
    logic       m_s, m_l, m_r, m_h;
    logic [7:0] m_cnt;
    logic       b, e, rr;

    // ---------------- vector table ----------------
    // reset, reset priority over a pressed button, release to IDLE
    add(1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    // 5-sample short press
    add_n(5, 1, 0, 1, 0);
    add(0, 0, 0, 1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1);
    // exactly 8 samples: long, nothing on release
    add_n(7, 1, 0, 1, 1);
    add(0, 1, 0, 0, 1, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1);
    // 15 samples with repeat: long @8, repeats @11 and @14
    add_n(7, 1, 1, 1, 1);
    add(0, 1, 1, 0, 1, 0, 1, 1);
    add_n(2, 1, 1, 1, 1);
    add(0, 1, 1, 0, 0, 1, 1, 1);
    add_n(2, 1, 1, 1, 1);
    add(0, 1, 1, 0, 0, 1, 1, 1);
    add_n(1, 1, 1, 1, 1);
    add(0, 0, 1, 0, 0, 0, 0, 1);
    // 15 samples without repeat
    add_n(7, 1, 0, 1, 1);
    add(0, 1, 0, 0, 1, 0, 1, 1);
    add_n(7, 1, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1);
    // repeat_en dropped mid-interval restarts the full interval
    add_n(7, 1, 1, 1, 1);
    add(0, 1, 1, 0, 1, 0, 1, 1);
    add(0, 1, 1, 0, 0, 0, 1, 1);
    add(0, 1, 0, 0, 0, 0, 1, 1);
    add(0, 1, 1, 0, 0, 0, 1, 1);
    add(0, 1, 1, 0, 0, 0, 1, 1);
    add(0, 1, 1, 0, 0, 1, 1, 1);
    add(0, 0, 1, 0, 0, 0, 0, 1);
    // reset during a hold: nothing until released and pressed again
    add_n(4, 1, 0, 1, 1);
    add(1, 1, 0, 0, 0, 0, 0, 0);
    add_n(10, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    add_n(3, 1, 0, 1, 0);
    add(0, 0, 0, 1, 0, 0, 0, 1);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].btn, vecs[i].ren);
      check($sformatf("vec%0d short", i), 32'(press_short),  32'(vecs[i].s));
      check($sformatf("vec%0d long", i),  32'(press_long),   32'(vecs[i].l));
      check($sformatf("vec%0d rep", i),   32'(repeat_pulse), 32'(vecs[i].r));
      check($sformatf("vec%0d held", i),  32'(held),         32'(vecs[i].h));
      check($sformatf("vec%0d count", i), 32'(press_count),  32'(vecs[i].cnt));
    end

    // ---------------- 256 one-sample presses, count wraps ----------------
    step(1, 0, 0);
    step(0, 0, 0);
    for (int i = 0; i < 256; i++) begin
      step(0, 1, 0);
      check($sformatf("wrap%0d held", i), 32'(held), 32'd1);
      check($sformatf("wrap%0d early", i), 32'(press_short), 32'd0);
      step(0, 0, 0);
      check($sformatf("wrap%0d short", i), 32'(press_short), 32'd1);
      check($sformatf("wrap%0d count", i), 32'(press_count), 32'((i + 1) % 256));
    end
    check("wrap final count", 32'(press_count), 32'd0);

    // ---------------- LONG_TICKS=2, REPEAT_TICKS=1 instance ----------------
    step_fast("f0", 1, 0, 0, 0, 0, 0, 0, 0);
    step_fast("f1", 0, 0, 0, 0, 0, 0, 0, 0);
    step_fast("f2", 0, 1, 1, 0, 0, 0, 1, 0);
    step_fast("f3", 0, 1, 1, 0, 1, 0, 1, 0);
    step_fast("f4", 0, 1, 1, 0, 0, 1, 1, 0);
    step_fast("f5", 0, 1, 1, 0, 0, 1, 1, 0);
    step_fast("f6", 0, 1, 0, 0, 0, 0, 1, 0);
    step_fast("f7", 0, 1, 1, 0, 0, 1, 1, 0);
    step_fast("f8", 0, 0, 1, 0, 0, 0, 0, 0);
    step_fast("f9", 0, 1, 0, 0, 0, 0, 1, 0);
    step_fast("f10", 0, 0, 0, 1, 0, 0, 0, 1);

    // ---------------- random stream vs run-length model ----------------
    b = 1'b0; e = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rr = (i == 0) || ($urandom_range(299) == 0);
      if ($urandom_range(9) == 0) b = ~b;
      if ($urandom_range(19) == 0) e = ~e;

      if (rr) begin
        armed = 0; run = 0; rrun = 0;
        m_s = 0; m_l = 0; m_r = 0; m_h = 0; m_cnt = 0;
      end else begin
        m_s = 0; m_l = 0; m_r = 0;
        if (!b) begin
          if (armed && run > 0 && run < LT) begin
            m_s = 1;
            m_cnt = m_cnt + 8'd1;
          end
          armed = 1; run = 0; rrun = 0; m_h = 0;
        end else if (!armed) begin
          m_h = 0;
        end else begin
          run++;
          m_h = 1;
          if (run == LT) begin
            m_l = 1;
            rrun = 0;
          end else if (run > LT) begin
            if (e) begin
              rrun++;
              if (rrun == RT) begin
                m_r = 1;
                rrun = 0;
              end
            end else begin
              rrun = 0;
            end
          end
        end
      end

      step(rr, b, e);
      check($sformatf("rnd%0d short", i), 32'(press_short),  32'(m_s));
      check($sformatf("rnd%0d long", i),  32'(press_long),   32'(m_l));
      check($sformatf("rnd%0d rep", i),   32'(repeat_pulse), 32'(m_r));
      check($sformatf("rnd%0d held", i),  32'(held),         32'(m_h));
      check($sformatf("rnd%0d count", i), 32'(press_count),  32'(m_cnt));
      check($sformatf("rnd%0d exclusive", i),
            32'(int'(press_short) + int'(press_long) + int'(repeat_pulse) <= 1), 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/detector_pulsacion.md
DETECTOR_PULSACION -- requirements
Module: detector_pulsacion

Interface
REQ-001 Parameter: LONG_TICKS, default 1000, held-sample count for a long press (1 s at 1 kHz); legal range 2..65535.
REQ-002 Parameter: REPEAT_TICKS, default 200, held-sample count between auto-repeat pulses after a long press; legal range 1..65535.
REQ-003 Port: clk_slow  input  1  sole clock (1 kHz); every register updates on its rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset, sampled on rising clk_slow.
REQ-005 Port: btn_stable  input  1  debounced button level, already synchronous to clk_slow; 1 = pressed.
REQ-006 Port: repeat_en  input  1  enables auto-repeat pulses while in long hold.
REQ-007 Port: press_short  output  1  one-cycle pulse on release of a press shorter than LONG_TICKS samples.
REQ-008 Port: press_long  output  1  one-cycle pulse when a hold reaches LONG_TICKS samples.
REQ-009 Port: repeat_pulse  output  1  one-cycle pulse every REPEAT_TICKS samples of continued hold after press_long.
REQ-010 Port: held  output  1  level; 1 while a press is being tracked (PRESSED or LONG_HELD).
REQ-011 Port: press_count  output  8  count of short presses, wraps modulo 256.

Function
REQ-012 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-013 FSM SHALL have exactly four states: WAIT_RELEASE, IDLE, PRESSED, LONG_HELD; internal hold counter 16 bits unsigned.
REQ-014 WAIT_RELEASE: btn_stable=0 -> IDLE; btn_stable=1 -> stay; no pulses, held=0.
REQ-015 IDLE: btn_stable=1 -> PRESSED with counter set to 1 (edge k = first sample of 1); btn_stable=0 -> stay.
REQ-016 PRESSED, btn_stable=1, counter==LONG_TICKS-1: press_long=1 for the following cycle, counter cleared to 0, -> LONG_HELD; press_long thus follows exactly LONG_TICKS consecutive 1 samples (edge k+LONG_TICKS-1).
REQ-017 PRESSED, btn_stable=1, counter<LONG_TICKS-1: counter increments, no pulse.
REQ-018 PRESSED, btn_stable=0: press_short=1 for the following cycle, press_count increments by 1 (255 -> 0), -> IDLE.
REQ-019 LONG_HELD, btn_stable=0: -> IDLE, no press_short, press_count unchanged, counter cleared.
REQ-020 LONG_HELD, btn_stable=1, repeat_en=1: counter increments; when counter==REPEAT_TICKS-1, repeat_pulse=1 for the following cycle and counter cleared; pulses at edges k+LONG_TICKS-1+n*REPEAT_TICKS, n>=1.
REQ-021 LONG_HELD, repeat_en=0: counter held at 0, no repeat_pulse; re-asserting repeat_en restarts the full REPEAT_TICKS interval.
REQ-022 REPEAT_TICKS=1 SHALL yield repeat_pulse on every cycle of continued hold.
REQ-023 press_short, press_long, repeat_pulse SHALL be mutually exclusive and each SHALL be high for exactly one clk_slow cycle per event.
REQ-024 held SHALL be 1 in the cycle after the transition into PRESSED through the cycle of the transition out of PRESSED/LONG_HELD (registered from next state).

Reset
REQ-025 rst=1 SHALL force state WAIT_RELEASE, counter 0, press_short=0, press_long=0, repeat_pulse=0, held=0, press_count=0 on the next rising edge, regardless of state.
REQ-026 rst asserted mid-press SHALL drop any pending event; a press in progress at reset release SHALL produce no event until btn_stable is sampled 0 then 1 again.
REQ-027 rst SHALL take priority over all inputs in the same cycle.

Verification (LONG_TICKS=8, REPEAT_TICKS=3)
REQ-028 Reset with btn_stable=0, then btn_stable=1 for 5 samples, then 0 -> press_short one cycle after first 0 sample, press_count=1, held returns to 0, no press_long.
REQ-029 btn_stable=1 for 8 samples exactly, then 0 -> press_long one cycle after 8th sample, no press_short on release, press_count unchanged.
REQ-030 btn_stable=1 for 15 samples, repeat_en=1 -> press_long after sample 8, repeat_pulse after samples 11 and 14, nothing on release; with repeat_en=0 -> no repeat_pulse.
REQ-031 Hold btn_stable=1 across rst pulse in middle of hold -> no pulses until release; next 3-sample press -> press_short, press_count=1.
REQ-032 256 short presses of 1 sample each, separated by 1 idle sample -> 256 press_short pulses, press_count wraps to 0.
REQ-033 Random btn_stable and repeat_en stream vs. reference model -> cycle-exact match on all outputs; pulses never overlap.
